div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_pkg.sv | 35 +++
 rtl/div_step.sv | 32 +++
 rtl/div_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg -- shared constants for the iterative divider.
//   XLEN / DIV_STEPS : datapath width and number of restoring steps
//   OP_*             : ALUControl encodings of the four divide operations
//   ST_*             : divider FSM state encoding
//   op_* helpers     : opcode classification used by the controller
package div_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_STEPS = 32;

  localparam logic [3:0] OP_DIV  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REM  = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic op_valid(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_signed(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [3:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step -- one combinational restoring-division step on magnitudes.
//   rem_in  : partial remainder entering the step
//   quo_in  : dividend bits still to be consumed (MSB first), with quotient
//             bits accumulating from the LSB end
//   divisor : divisor magnitude
//   rem_out : partial remainder after the trial subtraction
//   quo_out : quo_in shifted left with the new quotient bit appended
module div_step
  import div_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  // The shifted remainder needs one extra bit: remainder < divisor keeps it
  // below 2*divisor, which can exceed XLEN bits.
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;
  logic          fits;

  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    fits    = (shifted >= {1'b0, divisor});
    trial   = shifted - {1'b0, divisor};
    rem_out = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// div_unit -- 32-step iterative restoring divider (DIV/DIVU/REM/REMU).
//   clk, rst   : clock and synchronous active-high reset
//   start      : begin an operation (only honoured in IDLE with a divide code)
//   ALUControl : operation select, see div_pkg OP_* codes
//   A, B       : dividend and divisor, captured on the accept edge
//   flush      : abandon the current operation and return to IDLE
//   busy       : high while iterating (CALC)
//   done       : one-cycle pulse; Result is valid while it is high
//   Result     : quotient or remainder, held until the next completion
// Compile-time option: DIV_FASTPATH_EN -- divide-by-zero and signed overflow
// skip the iteration and complete the cycle after the accept edge.
module div_unit
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      ALUControl,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  logic [1:0]      state;
  logic [4:0]      count;
  logic [XLEN-1:0] rem_r, quo_r, dvsr_r, spec_val;
  logic            neg_quo, neg_rem, is_rem, special;
  logic [XLEN-1:0] rem_nx, quo_nx, final_val;

  logic            accept, a_neg, b_neg, in_div0, in_ovf, in_special;
  logic [XLEN-1:0] in_spec_val;

  div_step u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .divisor (dvsr_r),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  // Flush beats start in IDLE, so an operation is never accepted alongside it.
  assign accept = (state == ST_IDLE) && start && !flush && op_valid(ALUControl);
  assign a_neg  = op_signed(ALUControl) && A[XLEN-1];
  assign b_neg  = op_signed(ALUControl) && B[XLEN-1];

  // Divide-by-zero and INT_MIN / -1 have architecturally fixed results that
  // the magnitude iteration cannot produce, so they are resolved up front.
  assign in_div0     = (B == '0);
  assign in_ovf      = op_signed(ALUControl) && (A == INT_MIN) && (B == ALL_ONES);
  assign in_special  = in_div0 || in_ovf;
  assign in_spec_val = in_div0 ? (op_is_rem(ALUControl) ? A : ALL_ONES)
                               : (op_is_rem(ALUControl) ? '0 : INT_MIN);

  // Value written to Result on the final step, taken straight from the step
  // outputs so it lands on the same edge that enters DONE.
  always_comb begin
    final_val = '0;
    if (special)
      final_val = spec_val;
    else if (is_rem)
      final_val = neg_rem ? (~rem_nx + 1'b1) : rem_nx;
    else
      final_val = neg_quo ? (~quo_nx + 1'b1) : quo_nx;
  end

  assign busy = (state == ST_CALC);
  assign done = (state == ST_DONE);

  // Controller and datapath registers. Flush and reset both drop back to IDLE
  // without touching Result, except that reset also clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      Result   <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      dvsr_r   <= '0;
      spec_val <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      is_rem   <= 1'b0;
      special  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rem_r    <= '0;
            quo_r    <= a_neg ? (~A + 1'b1) : A;
            dvsr_r   <= b_neg ? (~B + 1'b1) : B;
            count    <= '0;
            neg_quo  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            is_rem   <= op_is_rem(ALUControl);
            special  <= in_special;
            spec_val <= in_spec_val;
`ifdef DIV_FASTPATH_EN
            if (in_special) begin
              state  <= ST_DONE;
              Result <= in_spec_val;
            end else begin
              state  <= ST_CALC;
            end
`else
            state    <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
            count <= '0;
          end else begin
            rem_r <= rem_nx;
            quo_r <= quo_nx;
            count <= count + 5'd1;
            if (count == 5'(DIV_STEPS - 1)) begin
              state  <= ST_DONE;
              Result <= final_val;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          count <= '0;
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule
